// File: rtl/execute_if.sv
// EX-stage bundle: ID/EX inputs, hazard-unit controls and the EX/MEM outputs.
// slave = the execute stage, master = whatever drives the ID/EX side.
interface execute_if #(
  parameter int XLEN = 32
);
  logic            ValidE;
  logic [XLEN-1:0] RD1E;
  logic [XLEN-1:0] RD2E;
  logic [XLEN-1:0] ImmExtE;
  logic [XLEN-1:0] PCE;
  logic [XLEN-1:0] PCPlus4E;
  logic [4:0]      RdE;
  logic [2:0]      funct3E;
  logic [3:0]      ALUControlE;
  logic            ALUSrcE;
  logic            RegWriteE;
  logic            MemWriteE;
  logic            BranchE;
  logic            JumpE;
  logic [1:0]      ResultSrcE;
  logic [1:0]      ForwardAE;
  logic [1:0]      ForwardBE;
  logic [XLEN-1:0] ResultW;
  logic            StallM;
  logic            FlushM;

  logic            PCSrcE;
  logic [XLEN-1:0] PCTargetE;
  logic            ValidM;
  logic            RegWriteM;
  logic            MemWriteM;
  logic [1:0]      ResultSrcM;
  logic [4:0]      RdM;
  logic [XLEN-1:0] ALUResultM;
  logic [XLEN-1:0] WriteDataM;
  logic [XLEN-1:0] PCPlus4M;

  modport master (
    output ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, funct3E, ALUControlE,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE,
           ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    input  PCSrcE, PCTargetE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  ValidE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE, funct3E, ALUControlE,
           ALUSrcE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE,
           ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    output PCSrcE, PCTargetE, ValidM, RegWriteM, MemWriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );
endinterface

// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and
// the EX/MEM pipeline register (flush beats stall).
module execute_stage #(
  parameter int XLEN = 32
) (
  input logic     clk,
  input logic     rst,
  execute_if.slave ex
);

  function automatic logic [XLEN-1:0] alu_op(input logic [3:0]      op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    logic [4:0]             shamt;
    a_s   = a;
    b_s   = b;
    shamt = b[4:0];
    case (op)
      4'b0001: alu_op = a - b;
      4'b0010: alu_op = a & b;
      4'b0011: alu_op = a | b;
      4'b0100: alu_op = a ^ b;
      4'b0101: alu_op = a << shamt;
      4'b0110: alu_op = {{(XLEN-1){1'b0}}, a_s < b_s};
      4'b0111: alu_op = {{(XLEN-1){1'b0}}, a < b};
      4'b1000: alu_op = a >> shamt;
      4'b1001: alu_op = a_s >>> shamt;
      default: alu_op = a + b;
    endcase
  endfunction

  function automatic logic branch_cond(input logic [2:0]      f3,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s;
    logic signed [XLEN-1:0] b_s;
    a_s = a;
    b_s = b;
    case (f3)
      3'b000:  branch_cond = (a == b);
      3'b001:  branch_cond = (a != b);
      3'b100:  branch_cond = (a_s < b_s);
      3'b101:  branch_cond = (a_s >= b_s);
      3'b110:  branch_cond = (a < b);
      3'b111:  branch_cond = (a >= b);
      default: branch_cond = 1'b0;
    endcase
  endfunction

  logic            valid_q, regwrite_q, memwrite_q;
  logic [1:0]      resultsrc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_result_q, write_data_q, pcplus4_q;

  logic            valid_d, regwrite_d, memwrite_d;
  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result_d;

  // Forwarding muxes; code 11 falls back to the register-file value.
  always_comb begin
    case (ex.ForwardAE)
      2'b10:   src_a = alu_result_q;
      2'b01:   src_a = ex.ResultW;
      default: src_a = ex.RD1E;
    endcase
    case (ex.ForwardBE)
      2'b10:   fwd_b = alu_result_q;
      2'b01:   fwd_b = ex.ResultW;
      default: fwd_b = ex.RD2E;
    endcase
    src_b = ex.ALUSrcE ? ex.ImmExtE : fwd_b;
  end

  assign alu_result_d = alu_op(ex.ALUControlE, src_a, src_b);
  assign valid_d      = ex.ValidE;
  assign regwrite_d   = ex.RegWriteE & ex.ValidE;
  assign memwrite_d   = ex.MemWriteE & ex.ValidE;

  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;
  assign ex.PCSrcE    = ex.ValidE &
                        (ex.JumpE | (ex.BranchE & branch_cond(ex.funct3E, src_a, fwd_b)));

  // EX/MEM boundary; a flush only clears control, data is left as is.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      resultsrc_q  <= 2'b00;
      rd_q         <= 5'd0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pcplus4_q    <= '0;
    end else if (ex.FlushM) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      memwrite_q   <= 1'b0;
      resultsrc_q  <= 2'b00;
      rd_q         <= 5'd0;
    end else if (!ex.StallM) begin
      valid_q      <= valid_d;
      regwrite_q   <= regwrite_d;
      memwrite_q   <= memwrite_d;
      resultsrc_q  <= ex.ResultSrcE;
      rd_q         <= ex.RdE;
      alu_result_q <= alu_result_d;
      write_data_q <= fwd_b;
      pcplus4_q    <= ex.PCPlus4E;
    end
  end

  assign ex.ValidM     = valid_q;
  assign ex.RegWriteM  = regwrite_q;
  assign ex.MemWriteM  = memwrite_q;
  assign ex.ResultSrcM = resultsrc_q;
  assign ex.RdM        = rd_q;
  assign ex.ALUResultM = alu_result_q;
  assign ex.WriteDataM = write_data_q;
  assign ex.PCPlus4M   = pcplus4_q;

endmodule
